// File: rtl/obj_det_pkg.sv
// ----------------------------------------------------------------------------
// obj_det_pkg
// Shared constants for the object-detection capture and read paths, plus the
// diff-buffer reader state type.
//   FRAME_W/FRAME_H/FRAME_SIZE : default frame geometry
//   ADDR_W/DATA_W              : diff BRAM address and word widths
//   X_W/Y_W                    : bounding-box column/row widths
//   ALERT_FRAMES               : default persistence depth for alerting
// ----------------------------------------------------------------------------
package obj_det_pkg;

    localparam int unsigned FRAME_W      = 320;
    localparam int unsigned FRAME_H      = 240;
    localparam int unsigned FRAME_SIZE   = FRAME_W * FRAME_H;
    localparam int unsigned ADDR_W       = 17;
    localparam int unsigned DATA_W       = 4;
    localparam int unsigned X_W          = 9;
    localparam int unsigned Y_W          = 8;
    localparam int unsigned ALERT_FRAMES = 3;

    // Fixed encodings kept for compatibility with older tooling and dumps.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    typedef enum logic [1:0] {
        RD_IDLE   = ST_IDLE,
        RD_SCAN   = ST_SCAN,
        RD_DRAIN  = ST_DRAIN,
        RD_REPORT = ST_REPORT
    } rd_state_t;

endpackage

// File: rtl/diff_buffer_reader_if.sv
// ----------------------------------------------------------------------------
// diff_buffer_reader_if
// Diff BRAM read port.
//   rd_addr : read address          (master -> slave)
//   rd_en   : port enable           (master -> slave)
//   rd_data : read data, 1-cycle latency after rd_en (slave -> master)
// ----------------------------------------------------------------------------
interface diff_buffer_reader_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 4
);
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_addr, output rd_en, input rd_data);
    modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/diff_buffer_reader_bbox_accum.sv
// ----------------------------------------------------------------------------
// bbox_accum
// Suspicious-pixel count and bounding-box accumulator.
//   clk, rst        : clock, async active-high reset
//   i_clear         : reinitialise accumulators for a new scan
//   i_valid, i_hit  : aligned pixel strobe and threshold result
//   i_x, i_y        : aligned pixel coordinates
//   o_*_nxt         : accumulator values including the current pixel
// ----------------------------------------------------------------------------
module bbox_accum #(
    parameter int unsigned FRAME_W = obj_det_pkg::FRAME_W,
    parameter int unsigned FRAME_H = obj_det_pkg::FRAME_H,
    parameter int unsigned ADDR_W  = obj_det_pkg::ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clear,
    input  logic                        i_valid,
    input  logic                        i_hit,
    input  logic [obj_det_pkg::X_W-1:0] i_x,
    input  logic [obj_det_pkg::Y_W-1:0] i_y,
    output logic [ADDR_W-1:0]           o_count_nxt,
    output logic [obj_det_pkg::X_W-1:0] o_x_min_nxt,
    output logic [obj_det_pkg::X_W-1:0] o_x_max_nxt,
    output logic [obj_det_pkg::Y_W-1:0] o_y_min_nxt,
    output logic [obj_det_pkg::Y_W-1:0] o_y_max_nxt
);
    import obj_det_pkg::*;

    localparam logic [X_W-1:0] X_LAST = X_W'(FRAME_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_H - 1);

    logic [ADDR_W-1:0] r_count;
    logic [X_W-1:0]    r_x_min, r_x_max;
    logic [Y_W-1:0]    r_y_min, r_y_max;
    logic              w_take;

    assign w_take = i_valid && i_hit;

    // Next values are exported so the reader can publish the final pixel's
    // contribution on the same edge it is accumulated.
    always_comb begin
        o_count_nxt = r_count;
        o_x_min_nxt = r_x_min;
        o_x_max_nxt = r_x_max;
        o_y_min_nxt = r_y_min;
        o_y_max_nxt = r_y_max;
        if (w_take) begin
            o_count_nxt = r_count + 1'b1;
            if (i_x < r_x_min) o_x_min_nxt = i_x;
            if (i_x > r_x_max) o_x_max_nxt = i_x;
            if (i_y < r_y_min) o_y_min_nxt = i_y;
            if (i_y > r_y_max) o_y_max_nxt = i_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_x_min <= X_LAST;
            r_x_max <= '0;
            r_y_min <= Y_LAST;
            r_y_max <= '0;
        end else if (i_clear) begin
            r_count <= '0;
            r_x_min <= X_LAST;
            r_x_max <= '0;
            r_y_min <= Y_LAST;
            r_y_max <= '0;
        end else begin
            r_count <= o_count_nxt;
            r_x_min <= o_x_min_nxt;
            r_x_max <= o_x_max_nxt;
            r_y_min <= o_y_min_nxt;
            r_y_max <= o_y_max_nxt;
        end
    end
endmodule

// File: rtl/diff_buffer_reader.sv
// ----------------------------------------------------------------------------
// diff_buffer_reader
// Scans the diff BRAM after each frame, counts pixels whose persistence is at
// least pixel_thresh, tracks their bounding box and raises an alert.
//   clk, reset                  : clock, async active-high reset
//   start_scan                  : one-cycle start pulse, honoured in IDLE
//   pixel_thresh, count_thresh  : per-pixel and per-frame thresholds
//   bram                        : diff BRAM read port (master modport)
//   busy, done, result_valid    : scan status
//   pixel_count, bbox_valid,
//   x_min/x_max/y_min/y_max     : results of the last completed scan
//   alert                       : alert level, updated with done
// Optional feature macro: ALERT_PERSIST_EN (alert only after ALERT_FRAMES
// consecutive over-threshold scans).
// ----------------------------------------------------------------------------
module diff_buffer_reader #(
    parameter int unsigned FRAME_W      = obj_det_pkg::FRAME_W,
    parameter int unsigned FRAME_H      = obj_det_pkg::FRAME_H,
    parameter int unsigned DATA_W       = obj_det_pkg::DATA_W,
    parameter int unsigned ADDR_W       = obj_det_pkg::ADDR_W,
    parameter int unsigned ALERT_FRAMES = obj_det_pkg::ALERT_FRAMES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_scan,
    input  logic [DATA_W-1:0]           pixel_thresh,
    input  logic [ADDR_W-1:0]           count_thresh,
    diff_buffer_reader_if.master        bram,
    output logic                        busy,
    output logic                        done,
    output logic                        result_valid,
    output logic [ADDR_W-1:0]           pixel_count,
    output logic                        bbox_valid,
    output logic [obj_det_pkg::X_W-1:0] x_min,
    output logic [obj_det_pkg::X_W-1:0] x_max,
    output logic [obj_det_pkg::Y_W-1:0] y_min,
    output logic [obj_det_pkg::Y_W-1:0] y_max,
    output logic                        alert
);
    import obj_det_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_W * FRAME_H - 1);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(FRAME_W - 1);

    rd_state_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [X_W-1:0]    r_x, r_x_d;
    logic [Y_W-1:0]    r_y, r_y_d;
    logic              r_vld_d;

    logic              r_done, r_result_valid, r_bbox_valid, r_alert;
    logic [ADDR_W-1:0] r_pixel_count;
    logic [X_W-1:0]    r_x_min, r_x_max;
    logic [Y_W-1:0]    r_y_min, r_y_max;

    logic              w_start, w_hit, w_publish, w_over, w_alert_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [X_W-1:0]    w_x_min_nxt, w_x_max_nxt;
    logic [Y_W-1:0]    w_y_min_nxt, w_y_max_nxt;

    assign w_start   = (r_state == RD_IDLE) && start_scan;
    assign w_hit     = bram.rd_data >= pixel_thresh;
    // The final word is accumulated while leaving DRAIN; results load from the
    // accumulator's next values on that edge so they are visible with done.
    assign w_publish = (r_state == RD_DRAIN);
    assign w_over    = w_cnt_nxt >= count_thresh;

    bbox_accum #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H),
        .ADDR_W  (ADDR_W)
    ) u_bbox_accum (
        .clk         (clk),
        .rst         (reset),
        .i_clear     (w_start),
        .i_valid     (r_vld_d),
        .i_hit       (w_hit),
        .i_x         (r_x_d),
        .i_y         (r_y_d),
        .o_count_nxt (w_cnt_nxt),
        .o_x_min_nxt (w_x_min_nxt),
        .o_x_max_nxt (w_x_max_nxt),
        .o_y_min_nxt (w_y_min_nxt),
        .o_y_max_nxt (w_y_max_nxt)
    );

    // FSM, address generator and coordinate pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RD_IDLE;
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_x_d   <= '0;
            r_y_d   <= '0;
            r_vld_d <= 1'b0;
        end else begin
            // Coordinates trail the issued address by the BRAM read latency.
            r_vld_d <= (r_state == RD_SCAN);
            r_x_d   <= r_x;
            r_y_d   <= r_y;
            case (r_state)
                RD_IDLE: begin
                    if (start_scan) begin
                        r_state <= RD_SCAN;
                        r_addr  <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                RD_SCAN: begin
                    if (r_addr == ADDR_LAST) begin
                        r_state <= RD_DRAIN;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                        if (r_x == X_LAST) begin
                            r_x <= '0;
                            r_y <= r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                RD_DRAIN:  r_state <= RD_REPORT;
                RD_REPORT: r_state <= RD_IDLE;
                default:   r_state <= RD_IDLE;
            endcase
        end
    end

`ifdef ALERT_PERSIST_EN
    localparam int unsigned   PCNT_W = $clog2(ALERT_FRAMES + 1);
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(ALERT_FRAMES);

    logic [PCNT_W-1:0] r_persist;
    logic [PCNT_W-1:0] w_persist_nxt;

    always_comb begin
        w_persist_nxt = '0;
        if (w_over) begin
            w_persist_nxt = (r_persist == PCNT_MAX) ? r_persist : r_persist + 1'b1;
        end
    end

    assign w_alert_nxt = (w_persist_nxt >= PCNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_persist <= '0;
        end else if (w_publish) begin
            r_persist <= w_persist_nxt;
        end
    end
`else
    assign w_alert_nxt = w_over;
`endif

    // Published results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done         <= 1'b0;
            r_result_valid <= 1'b0;
            r_pixel_count  <= '0;
            r_bbox_valid   <= 1'b0;
            r_x_min        <= '0;
            r_x_max        <= '0;
            r_y_min        <= '0;
            r_y_max        <= '0;
            r_alert        <= 1'b0;
        end else begin
            r_done <= w_publish;
            if (w_publish) begin
                r_result_valid <= 1'b1;
                r_pixel_count  <= w_cnt_nxt;
                r_bbox_valid   <= (w_cnt_nxt != '0);
                r_alert        <= w_alert_nxt;
                if (w_cnt_nxt != '0) begin
                    r_x_min <= w_x_min_nxt;
                    r_x_max <= w_x_max_nxt;
                    r_y_min <= w_y_min_nxt;
                    r_y_max <= w_y_max_nxt;
                end else begin
                    r_x_min <= '0;
                    r_x_max <= '0;
                    r_y_min <= '0;
                    r_y_max <= '0;
                end
            end
        end
    end

    assign bram.rd_addr = r_addr;
    assign bram.rd_en   = (r_state == RD_SCAN);
    assign busy         = (r_state != RD_IDLE);
    assign done         = r_done;
    assign result_valid = r_result_valid;
    assign pixel_count  = r_pixel_count;
    assign bbox_valid   = r_bbox_valid;
    assign x_min        = r_x_min;
    assign x_max        = r_x_max;
    assign y_min        = r_y_min;
    assign y_max        = r_y_max;
    assign alert        = r_alert;
endmodule

// File: tb/tb_diff_buffer_reader.sv
// ----------------------------------------------------------------------------
// tb_diff_buffer_reader
// Self-checking bench for diff_buffer_reader on a reduced 20x12 frame, with a
// behavioural BRAM and a frame-level reference model of the scan results.
// ----------------------------------------------------------------------------
module tb_diff_buffer_reader;

    localparam int TW = 20;
    localparam int TH = 12;
    localparam int TN = TW * TH;
    localparam int AW = 17;
    localparam int DW = 4;
    localparam int AF = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_scan;
    logic [DW-1:0] pixel_thresh;
    logic [AW-1:0] count_thresh;
    logic          busy, done, result_valid, bbox_valid, alert;
    logic [AW-1:0] pixel_count;
    logic [8:0]    x_min, x_max;
    logic [7:0]    y_min, y_max;

    always #5 clk = ~clk;

    diff_buffer_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bram_if ();

    diff_buffer_reader #(
        .FRAME_W      (TW),
        .FRAME_H      (TH),
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .ALERT_FRAMES (AF)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start_scan   (start_scan),
        .pixel_thresh (pixel_thresh),
        .count_thresh (count_thresh),
        .bram         (bram_if),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .pixel_count  (pixel_count),
        .bbox_valid   (bbox_valid),
        .x_min        (x_min),
        .x_max        (x_max),
        .y_min        (y_min),
        .y_max        (y_max),
        .alert        (alert)
    );

    // Behavioural BRAM: one-cycle read latency
    logic [DW-1:0] mem [TN];

    always @(posedge clk) begin
        if (bram_if.rd_en) bram_if.rd_data <= mem[int'(bram_if.rd_addr) % TN];
    end

    // Observation of the read address stream and done pulses
    int addr_q [$];
    int done_cnt;

    always @(negedge clk) begin
        if (bram_if.rd_en) addr_q.push_back(int'(bram_if.rd_addr));
        if (done) done_cnt++;
    end

    int n_vec = 0;
    int n_err = 0;
    int m_persist = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame-level reference: scan the whole image by coordinates.
    task automatic model_scan(input int pt, input int ct,
                              output int cnt, output int xmn, output int xmx,
                              output int ymn, output int ymx, output int bv,
                              output int al);
        int ge;
        cnt = 0; xmn = TW; xmx = -1; ymn = TH; ymx = -1;
        for (int y = 0; y < TH; y++) begin
            for (int x = 0; x < TW; x++) begin
                if (int'(mem[y * TW + x]) >= pt) begin
                    cnt++;
                    if (x < xmn) xmn = x;
                    if (x > xmx) xmx = x;
                    if (y < ymn) ymn = y;
                    if (y > ymx) ymx = y;
                end
            end
        end
        bv = (cnt != 0) ? 1 : 0;
        if (cnt == 0) begin
            xmn = 0; xmx = 0; ymn = 0; ymx = 0;
        end
        ge = (cnt >= ct) ? 1 : 0;
`ifdef ALERT_PERSIST_EN
        m_persist = ge ? ((m_persist < AF) ? m_persist + 1 : AF) : 0;
        al = (m_persist >= AF) ? 1 : 0;
`else
        al = ge;
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},  32'(bram_if.rd_en), 0);
        check({tag, "_rd_addr"}, 32'(bram_if.rd_addr), 0);
        check({tag, "_busy"},   32'(busy), 0);
        check({tag, "_done"},   32'(done), 0);
        check({tag, "_rvalid"}, 32'(result_valid), 0);
        check({tag, "_count"},  32'(pixel_count), 0);
        check({tag, "_bbv"},    32'(bbox_valid), 0);
        check({tag, "_bbox"},   32'({x_min, x_max, y_min, y_max}), 0);
        check({tag, "_alert"},  32'(alert), 0);
    endtask

    task automatic run_scan(input string name, input int pt, input int ct, input int repulse_at);
        int cnt, xmn, xmx, ymn, ymx, bv, al, lat, bad;
        model_scan(pt, ct, cnt, xmn, xmx, ymn, ymx, bv, al);
        @(negedge clk);
        pixel_thresh = DW'(pt);
        count_thresh = AW'(ct);
        addr_q.delete();
        done_cnt = 0;
        start_scan = 1'b1;
        @(posedge clk);
        #1 start_scan = 1'b0;
        check({name, "_busy"}, 32'(busy), 1);
        lat = 1;
        while (lat < TN + 20) begin
            @(posedge clk);
            #1;
            lat++;
            start_scan = (lat == repulse_at);
            if (done) break;
        end
        start_scan = 1'b0;
        check({name, "_latency"}, lat, TN + 2);
        check({name, "_rvalid"}, 32'(result_valid), 1);
        check({name, "_count"}, 32'(pixel_count), cnt);
        check({name, "_bbv"}, 32'(bbox_valid), bv);
        check({name, "_xmin"}, 32'(x_min), xmn);
        check({name, "_xmax"}, 32'(x_max), xmx);
        check({name, "_ymin"}, 32'(y_min), ymn);
        check({name, "_ymax"}, 32'(y_max), ymx);
        check({name, "_alert"}, 32'(alert), al);
        @(posedge clk);
        #1;
        check({name, "_done_width"}, 32'(done), 0);
        check({name, "_idle"}, 32'(busy), 0);
        check({name, "_done_cnt"}, done_cnt, 1);
        bad = 0;
        foreach (addr_q[i]) if (addr_q[i] != i) bad++;
        check({name, "_addr_len"}, addr_q.size(), TN);
        check({name, "_addr_seq"}, bad, 0);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < TN; i++) mem[i] = DW'(v);
    endtask

    initial begin
        reset = 1'b1;
        start_scan = 1'b0;
        pixel_thresh = '0;
        count_thresh = '0;
        fill(0);
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("rst");
        @(negedge clk) reset = 1'b0;
        repeat (2) @(posedge clk);

        // Empty frame
        run_scan("empty", 1, 10, -1);

        // Two separated hits
        fill(0);
        mem[4 * TW + 3] = 4'd5;
        mem[10 * TW + 17] = 4'd5;
        run_scan("two_hits", 3, 2, -1);

        // Frame corners: pipeline alignment at both ends
        fill(0);
        mem[0] = 4'd9;
        run_scan("first_px", 1, 1, -1);
        fill(0);
        mem[TN - 1] = 4'd9;
        run_scan("last_px", 1, 1, -1);

        // Threshold 0 flags every pixel
        for (int i = 0; i < TN; i++) mem[i] = DW'($urandom_range(0, 15));
        run_scan("thr_zero", 0, TN, -1);

        // Re-pulse of start mid-scan is ignored
        run_scan("repulse", 8, 20, 100);

        // Random frames
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < TN; i++)
                mem[i] = ($urandom_range(0, 5) == 0) ? DW'($urandom_range(1, 15)) : '0;
            run_scan($sformatf("rnd%0d", s), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, TN / 8)), -1);
        end

        // Reset in the middle of a scan
        fill(15);
        @(negedge clk);
        pixel_thresh = 4'd1;
        start_scan = 1'b1;
        @(posedge clk);
        #1 start_scan = 1'b0;
        repeat (50) @(posedge clk);
        #1 reset = 1'b1;
        m_persist = 0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        run_scan("after_rst", 4, 5, -1);

        // Alert persistence: three over-threshold scans, then one under
        fill(0);
        for (int i = 0; i < 30; i++) mem[i * 7] = 4'd6;
        run_scan("pers1", 5, 10, -1);
        run_scan("pers2", 5, 10, -1);
        run_scan("pers3", 5, 10, -1);
        run_scan("pers4", 5, 200, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
